// File: rtl/reorder_buffer_pkg.sv
// Shared widths and index types for the reorder buffer and its neighbours.
package reorder_buffer_pkg;
  localparam int ROB_SIZE = 16;
  localparam int ROB_WID  = 4;
  localparam int WID32    = 32;
  localparam int WIDREG   = 5;

  typedef logic [ROB_WID-1:0] rob_idx_t;
  typedef logic [ROB_WID:0]   rob_cnt_t;
  typedef logic [WIDREG-1:0]  reg_idx_t;
  typedef logic [WID32-1:0]   word_t;
endpackage

// File: rtl/reorder_buffer.sv
// 16-entry circular reorder buffer: in-order issue, CDB capture, in-order
// commit, and a head-of-buffer mispredict flush.
module reorder_buffer
  import reorder_buffer_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             issue_valid,
  input  logic [WIDREG-1:0] issue_rd,
  input  logic             issue_is_br,
  input  logic             issue_pred_taken,
  input  logic [WID32-1:0] issue_pc,
  output logic [ROB_WID-1:0] issue_pos,
  output logic             full,
  input  logic             cdb_valid,
  input  logic [ROB_WID-1:0] cdb_pos,
  input  logic [WID32-1:0] cdb_val,
  input  logic             cdb_taken,
  input  logic [WID32-1:0] cdb_target,
  input  logic [ROB_WID-1:0] q1_pos,
  input  logic [ROB_WID-1:0] q2_pos,
  output logic             q1_ready,
  output logic             q2_ready,
  output logic [WID32-1:0] q1_val,
  output logic [WID32-1:0] q2_val,
  output logic             commit_valid,
  output logic [WIDREG-1:0] commit_rd,
  output logic [WID32-1:0] commit_val,
  output logic [ROB_WID-1:0] commit_pos,
  output logic             rollback,
  output logic [WID32-1:0] rollback_pc
);

  logic     busy_q  [ROB_SIZE];
  logic     ready_q [ROB_SIZE];
  reg_idx_t rd_q    [ROB_SIZE];
  word_t    val_q   [ROB_SIZE];
  logic     is_br_q [ROB_SIZE];
  logic     pred_q  [ROB_SIZE];
  logic     real_q  [ROB_SIZE];
  word_t    pc_q    [ROB_SIZE];
  word_t    tgt_q   [ROB_SIZE];

  rob_idx_t head_q, head_d, tail_q, tail_d;
  rob_cnt_t count_q, count_d;
  logic     cv_q, cv_d, rb_q, rb_d;
  reg_idx_t crd_q, crd_d;
  word_t    cval_q, cval_d, rbpc_q, rbpc_d;
  rob_idx_t cpos_q, cpos_d;

  logic live, issue_fire, cdb_fire, head_done, head_mis, do_commit, do_flush;

  // Nothing but clearing the pulses happens while a rollback is visible.
  assign live       = rdy && !rb_q;
  assign full       = (count_q == rob_cnt_t'(ROB_SIZE));
  assign issue_pos  = tail_q;
  assign issue_fire = live && issue_valid && !full;
  assign cdb_fire   = live && cdb_valid && busy_q[cdb_pos];
  assign head_done  = busy_q[head_q] && ready_q[head_q];
  assign head_mis   = is_br_q[head_q] && (real_q[head_q] != pred_q[head_q]);
  assign do_commit  = live && head_done && !head_mis;
  assign do_flush   = live && head_done && head_mis;

  assign q1_ready = ready_q[q1_pos] || (cdb_valid && cdb_pos == q1_pos);
  assign q2_ready = ready_q[q2_pos] || (cdb_valid && cdb_pos == q2_pos);
  assign q1_val   = (cdb_valid && cdb_pos == q1_pos) ? cdb_val : val_q[q1_pos];
  assign q2_val   = (cdb_valid && cdb_pos == q2_pos) ? cdb_val : val_q[q2_pos];

  assign commit_valid = cv_q;
  assign commit_rd    = crd_q;
  assign commit_val   = cval_q;
  assign commit_pos   = cpos_q;
  assign rollback     = rb_q;
  assign rollback_pc  = rbpc_q;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    cv_d    = cv_q;
    crd_d   = crd_q;
    cval_d  = cval_q;
    cpos_d  = cpos_q;
    rb_d    = rb_q;
    rbpc_d  = rbpc_q;
    if (rdy) begin
      cv_d = do_commit;
      rb_d = do_flush;
      if (do_commit) begin
        // Correctly predicted branches retire without a register write.
        crd_d  = is_br_q[head_q] ? '0 : rd_q[head_q];
        cval_d = val_q[head_q];
        cpos_d = head_q;
        head_d = head_q + rob_idx_t'(1);
      end
      if (do_flush) begin
        rbpc_d  = real_q[head_q] ? tgt_q[head_q] : pc_q[head_q] + word_t'(4);
        head_d  = '0;
        tail_d  = '0;
        count_d = '0;
      end else begin
        if (issue_fire) tail_d = tail_q + rob_idx_t'(1);
        count_d = count_q + rob_cnt_t'(issue_fire) - rob_cnt_t'(do_commit);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      cv_q    <= 1'b0;
      crd_q   <= '0;
      cval_q  <= '0;
      cpos_q  <= '0;
      rb_q    <= 1'b0;
      rbpc_q  <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      cv_q    <= cv_d;
      crd_q   <= crd_d;
      cval_q  <= cval_d;
      cpos_q  <= cpos_d;
      rb_q    <= rb_d;
      rbpc_q  <= rbpc_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ROB_SIZE; i++) begin
        busy_q[i]  <= 1'b0;
        ready_q[i] <= 1'b0;
      end
    end else if (do_flush) begin
      for (int i = 0; i < ROB_SIZE; i++) begin
        busy_q[i]  <= 1'b0;
        ready_q[i] <= 1'b0;
      end
    end else begin
      if (issue_fire) begin
        busy_q[tail_q]  <= 1'b1;
        ready_q[tail_q] <= 1'b0;
      end
      if (cdb_fire) ready_q[cdb_pos] <= 1'b1;
      // Retire last so a same-cycle CDB hit on the head cannot resurrect it.
      if (do_commit) begin
        busy_q[head_q]  <= 1'b0;
        ready_q[head_q] <= 1'b0;
      end
    end
  end

  // Payload fields are qualified by busy/ready, so they need no reset.
  always_ff @(posedge clk) begin
    if (issue_fire) begin
      rd_q[tail_q]    <= issue_rd;
      is_br_q[tail_q] <= issue_is_br;
      pred_q[tail_q]  <= issue_pred_taken;
      pc_q[tail_q]    <= issue_pc;
    end
    if (cdb_fire) begin
      val_q[cdb_pos]  <= cdb_val;
      real_q[cdb_pos] <= cdb_taken;
      tgt_q[cdb_pos]  <= cdb_target;
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer with hand-computed expectations.
module tb_reorder_buffer;
  logic        clk = 1'b0;
  logic        rst, rdy;
  logic        issue_valid, issue_is_br, issue_pred_taken;
  logic [4:0]  issue_rd;
  logic [31:0] issue_pc;
  logic [3:0]  issue_pos;
  logic        full;
  logic        cdb_valid, cdb_taken;
  logic [3:0]  cdb_pos;
  logic [31:0] cdb_val, cdb_target;
  logic [3:0]  q1_pos, q2_pos;
  logic        q1_ready, q2_ready;
  logic [31:0] q1_val, q2_val;
  logic        commit_valid;
  logic [4:0]  commit_rd;
  logic [31:0] commit_val;
  logic [3:0]  commit_pos;
  logic        rollback;
  logic [31:0] rollback_pc;

  int n_chk = 0;
  int n_pass = 0;

  reorder_buffer dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_is_br(issue_is_br),
    .issue_pred_taken(issue_pred_taken), .issue_pc(issue_pc),
    .issue_pos(issue_pos), .full(full),
    .cdb_valid(cdb_valid), .cdb_pos(cdb_pos), .cdb_val(cdb_val),
    .cdb_taken(cdb_taken), .cdb_target(cdb_target),
    .q1_pos(q1_pos), .q2_pos(q2_pos), .q1_ready(q1_ready), .q2_ready(q2_ready),
    .q1_val(q1_val), .q2_val(q2_val),
    .commit_valid(commit_valid), .commit_rd(commit_rd), .commit_val(commit_val),
    .commit_pos(commit_pos), .rollback(rollback), .rollback_pc(rollback_pc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    issue_valid = 0; issue_rd = '0; issue_is_br = 0; issue_pred_taken = 0; issue_pc = '0;
    cdb_valid = 0; cdb_pos = '0; cdb_val = '0; cdb_taken = 0; cdb_target = '0;
  endtask

  task automatic do_reset();
    idle();
    rdy = 1;
    rst = 1;
    tick();
    rst = 0;
  endtask

  task automatic issue(input logic [4:0] rd, input logic br, input logic pred, input logic [31:0] pc);
    issue_valid = 1; issue_rd = rd; issue_is_br = br; issue_pred_taken = pred; issue_pc = pc;
    tick();
    issue_valid = 0;
  endtask

  task automatic cdb(input logic [3:0] pos, input logic [31:0] val, input logic tk, input logic [31:0] tgt);
    cdb_valid = 1; cdb_pos = pos; cdb_val = val; cdb_taken = tk; cdb_target = tgt;
    tick();
    cdb_valid = 0;
  endtask

  initial begin
    q1_pos = '0; q2_pos = '0;
    idle();
    rdy = 1;
    rst = 1;
    #2;
    chk("rst_commit_valid", 32'(commit_valid), 0);
    chk("rst_rollback", 32'(rollback), 0);
    chk("rst_rollback_pc", rollback_pc, 0);
    chk("rst_issue_pos", 32'(issue_pos), 0);
    chk("rst_full", 32'(full), 0);
    tick();
    rst = 0;

    // Single issue / complete / commit
    issue_valid = 1; issue_rd = 5; issue_pc = 32'h100; #1;
    chk("t1_issue_pos", 32'(issue_pos), 0);
    tick(); issue_valid = 0;
    cdb(0, 32'hDEAD, 0, 0);
    chk("t1_no_early_commit", 32'(commit_valid), 0);
    tick();
    chk("t1_commit_valid", 32'(commit_valid), 1);
    chk("t1_commit_rd", 32'(commit_rd), 5);
    chk("t1_commit_val", commit_val, 32'hDEAD);
    chk("t1_commit_pos", 32'(commit_pos), 0);
    chk("t1_count", 32'(dut.count_q), 0);
    tick();
    chk("t1_pulse_clear", 32'(commit_valid), 0);

    // Fill to 16, protocol violation, wrap
    do_reset();
    for (int i = 0; i < 16; i++) begin
      chk("t2_pos", 32'(issue_pos), 32'(i));
      issue(5'(i + 1), 0, 0, 32'h1000 + 32'(i * 4));
    end
    chk("t2_full", 32'(full), 1);
    chk("t2_count16", 32'(dut.count_q), 16);
    issue(5'd31, 0, 0, 32'hBAD);
    chk("t2_ovf_count", 32'(dut.count_q), 16);
    chk("t2_ovf_tail", 32'(issue_pos), 0);
    cdb(0, 32'h11, 0, 0);
    chk("t2_full_held", 32'(full), 1);
    tick();
    chk("t2_commit", 32'(commit_valid), 1);
    chk("t2_commit_rd", 32'(commit_rd), 1);
    chk("t2_full_freed", 32'(full), 0);
    chk("t2_wrap_pos", 32'(issue_pos), 0);
    issue(5'd9, 0, 0, 32'h2000);
    chk("t2_full_again", 32'(full), 1);

    // Out-of-order completion, in-order commit
    do_reset();
    issue(1, 0, 0, 32'h10);
    issue(2, 0, 0, 32'h14);
    issue(3, 0, 0, 32'h18);
    cdb(2, 32'h22, 0, 0);
    chk("t3_hold2", 32'(commit_valid), 0);
    cdb(1, 32'h21, 0, 0);
    chk("t3_hold1", 32'(commit_valid), 0);
    cdb(0, 32'h20, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t3_cv", 32'(commit_valid), 1);
      chk("t3_pos", 32'(commit_pos), 32'(i));
      chk("t3_val", commit_val, 32'h20 + 32'(i));
      chk("t3_rd", 32'(commit_rd), 32'(i + 1));
    end
    tick();
    chk("t3_done", 32'(commit_valid), 0);

    // Mispredict taken with younger completed entries
    do_reset();
    issue(0, 1, 0, 32'h200);
    issue(7, 0, 0, 32'h204);
    issue(8, 0, 0, 32'h208);
    cdb(1, 32'h1, 0, 0);
    cdb(2, 32'h2, 0, 0);
    cdb(0, 32'h0, 1, 32'h400);
    tick();
    chk("t4_rollback", 32'(rollback), 1);
    chk("t4_rb_pc", rollback_pc, 32'h400);
    chk("t4_no_commit", 32'(commit_valid), 0);
    chk("t4_count", 32'(dut.count_q), 0);
    issue_valid = 1; issue_rd = 3; issue_pc = 32'h500;
    cdb_valid = 1; cdb_pos = 1; cdb_val = 32'h99;
    tick();
    idle();
    chk("t4_rb_clear", 32'(rollback), 0);
    chk("t4_issue_ignored", 32'(dut.count_q), 0);
    chk("t4_tail", 32'(issue_pos), 0);
    tick();
    chk("t4_young_gone1", 32'(commit_valid), 0);
    tick();
    chk("t4_young_gone2", 32'(commit_valid), 0);

    // Mispredict not-taken, then a correctly predicted branch
    do_reset();
    issue(0, 1, 1, 32'h200);
    cdb(0, 32'h0, 0, 32'h800);
    tick();
    chk("t4b_rollback", 32'(rollback), 1);
    chk("t4b_rb_pc", rollback_pc, 32'h204);
    do_reset();
    issue(9, 1, 1, 32'h300);
    cdb(0, 32'h5, 1, 32'h600);
    tick();
    chk("t4c_commit", 32'(commit_valid), 1);
    chk("t4c_rd_zero", 32'(commit_rd), 0);
    chk("t4c_no_rb", 32'(rollback), 0);

    // Forwarding and rdy stall
    do_reset();
    for (int i = 0; i < 4; i++) issue(5'(10 + i), 0, 0, 32'h40 + 32'(i * 4));
    q1_pos = 3; q2_pos = 0;
    cdb_valid = 1; cdb_pos = 3; cdb_val = 7; #1;
    chk("t5_fwd_ready", 32'(q1_ready), 1);
    chk("t5_fwd_val", q1_val, 7);
    chk("t5_q2_notready", 32'(q2_ready), 0);
    tick(); cdb_valid = 0; #1;
    chk("t5_stored_ready", 32'(q1_ready), 1);
    chk("t5_stored_val", q1_val, 7);
    cdb(0, 32'hA0, 0, 0);
    rdy = 0;
    cdb_valid = 1; cdb_pos = 1; cdb_val = 32'hB1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t5_stall_cv", 32'(commit_valid), 0);
      chk("t5_stall_count", 32'(dut.count_q), 4);
    end
    cdb_valid = 0;
    rdy = 1;
    tick();
    chk("t5_resume_cv", 32'(commit_valid), 1);
    chk("t5_resume_val", commit_val, 32'hA0);
    rdy = 0;
    tick();
    chk("t5_pulse_held", 32'(commit_valid), 1);
    chk("t5_held_count", 32'(dut.count_q), 3);
    rdy = 1;
    tick();
    chk("t5_pos1_not_ready", 32'(commit_valid), 0);

    // Asynchronous reset mid-cycle
    do_reset();
    for (int i = 0; i < 6; i++) issue(5'(i + 1), 0, 0, 32'h80 + 32'(i * 4));
    cdb(0, 32'h55, 0, 0);
    tick();
    chk("t6_pre_cv", 32'(commit_valid), 1);
    chk("t6_pre_count", 32'(dut.count_q), 5);
    #2 rst = 1;
    #1;
    chk("t6_cv", 32'(commit_valid), 0);
    chk("t6_rd", 32'(commit_rd), 0);
    chk("t6_val", commit_val, 0);
    chk("t6_issue_pos", 32'(issue_pos), 0);
    chk("t6_count", 32'(dut.count_q), 0);
    tick();
    rst = 0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
- 16-entry circular reorder buffer for the out-of-order RISC-V core.
- Accepts instructions in program order from the issue/decode stage and captures results from the common data bus (CDB).
- Commits completed results in order to the register file, which sits directly downstream.
- Detects branch mispredicts at the head and drives the global rollback that flushes the register file's rename tags.

Parameters:
- ROB_SIZE, 16, number of entries.
- ROB_WID, 4, entry index width (log2 ROB_SIZE).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- rdy  in  1  global enable; when low, all state holds
- issue_valid  in  1  push one instruction this cycle
- issue_rd  in  5  destination register; 0 means no writeback
- issue_is_br  in  1  entry is a conditional branch
- issue_pred_taken  in  1  predictor decision
- issue_pc  in  32  instruction PC
- issue_pos  out  4  tail index assigned to the pushed instruction (combinational)
- full  out  1  no free entry (combinational)
- cdb_valid  in  1  result broadcast
- cdb_pos  in  4  ROB index of the broadcast
- cdb_val  in  32  result value
- cdb_taken  in  1  actual branch outcome
- cdb_target  in  32  branch target
- q1_pos, q2_pos  in  4  operand lookups from issue
- q1_ready, q2_ready  out  1  value available (combinational)
- q1_val, q2_val  out  32  value (combinational)
- commit_valid  out  1  one-cycle commit pulse (registered)
- commit_rd  out  5  destination of the commit
- commit_val  out  32  committed value
- commit_pos  out  4  ROB index committed; the register file clears its tag if it matches
- rollback  out  1  one-cycle flush pulse (registered)
- rollback_pc  out  32  fetch redirect target

Behaviour:
- Reset (async): head=0, tail=0, count=0, all busy/ready=0, commit_valid=0, commit_rd=0, commit_val=0, commit_pos=0, rollback=0, rollback_pc=0.
- Per-entry state: busy, ready, rd, val, is_br, pred_taken, real_taken, pc, target.
- Issue:
  - Accepted when issue_valid && !full && !rollback && rdy.
  - Writes the entry at tail with busy=1, ready=0; tail increments modulo 16; count++.
  - issue_valid while full is a protocol violation; the bench flags it and it must not corrupt state.
- CDB capture:
  - When cdb_valid && entry[cdb_pos].busy: set ready=1, val=cdb_val, real_taken=cdb_taken, target=cdb_target.
  - A broadcast to a non-busy entry is ignored.
- Commit: at most one per cycle, registered, when entry[head].busy && ready.
  - Non-branch, or branch with real_taken==pred_taken: commit_valid=1 with rd/val/pos; head++; count--. Correctly predicted branches commit with rd=0.
  - Mispredicted branch: rollback=1; rollback_pc = target if real_taken, else pc+4; commit_valid=0.
  - Flush on the same edge: head=tail=count=0 and all busy=0.
- Latency: a CDB write to the head entry at edge N commits at edge N+1, so commit_valid is seen in the cycle after N+1.
- Simultaneous issue and commit in the same cycle: count unchanged; both pointers advance.
- full = (count==16). A commit in the current cycle does not relieve full until the next cycle.
- Pointer wrap-around: tail 15→0 and head 15→0, with count disambiguating empty from full.
- Query forwarding:
  - q_ready = entry[q_pos].ready || (cdb_valid && cdb_pos==q_pos).
  - q_val takes the CDB value when forwarding, else the stored val.
- Rollback cycle (rollback output high): issue and CDB inputs are ignored; pulses clear on the next rdy edge.
- rdy low: every register, including the pulse outputs, holds. Downstream stages are rdy-gated as well, so a held pulse is not double-consumed.
- Reset asserted mid-operation clears everything immediately, independent of clk and rdy.

Decomposition:
- Shared def package holds:
  - ROB_SIZE and ROB_WID, replacing the literal 4'b0 tag widths.
  - Existing WID32 and WIDREG.
  - Width macros for ROB index.
- No sub-module; entries are flat arrays inside reorder_buffer.

Test Plan:
- Reset, then issue rd=5 at pc=0x100; CDB pos=0 val=0xDEAD → next cycle commit_valid=1, commit_rd=5, commit_val=0xDEAD, commit_pos=0; count returns to 0.
- Issue 16 instructions → full=1 and issue_pos wraps 0..15. CDB completes pos 0 → after the commit, full=0 and the next issue gets pos 0 (wrap).
- Out-of-order CDB: complete pos 2 then 1 then 0 → commits appear in order 0, 1, 2, one per cycle.
- Branch at pc=0x200, pred_taken=0, CDB taken=1, target=0x400 with two younger entries → rollback=1, rollback_pc=0x400; next cycle count=0 and younger entries never commit. Second run with not-taken actual → rollback_pc=0x204.
- Forwarding: q1_pos=3 while cdb_valid with pos=3, val=7 → q1_ready=1, q1_val=7 in the same cycle. rdy=0 for 3 cycles mid-stream → no state change and no extra commits.
- Assert rst asynchronously between clock edges while count=5 → all outputs read 0 before the next edge.
